// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, taken branch and multi-cycle memory.
// Optional perf counters (stall_cycles, flush_count) are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter int RA_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            idex_mem_read,
  input  logic [RA_W-1:0] idex_rt,
  input  logic            exmem_branch,
  input  logic            exmem_zero,
  input  logic            exmem_mem_read,
  input  logic            exmem_mem_write,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_src,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_write,
  output logic            idex_flush,
  output logic            exmem_hold,
  output logic            exmem_flush,
  output logic            mem_timeout,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_BR_FLUSH   = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic mem_busy, take_br, load_use;
  logic freeze, do_branch, do_load_stall, do_abort;

  assign mem_busy = (exmem_mem_read | exmem_mem_write) & ~mem_ready;
  assign take_br  = exmem_branch & exmem_zero;
  assign load_use = idex_mem_read & (idex_rt != '0) & ((idex_rt == id_rs) | (idex_rt == id_rt));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    do_branch     = 1'b0;
    do_load_stall = 1'b0;
    do_abort      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          freeze     = 1'b1;
          wait_cnt_d = CNT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else if (take_br) begin
          do_branch = 1'b1;
          state_d   = ST_BR_FLUSH;
        end else if (load_use) begin
          do_load_stall = 1'b1;
          state_d       = ST_LOAD_STALL;
        end
      end
      // Single-cycle shadow states: only a new memory stall can interrupt them.
      ST_LOAD_STALL, ST_BR_FLUSH: begin
        if (mem_busy) begin
          freeze     = 1'b1;
          wait_cnt_d = CNT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          // Abandon the stuck access: bubble EX/MEM and let the pipeline move on.
          do_abort      = 1'b1;
          mem_timeout_d = 1'b1;
          wait_cnt_d    = '0;
          state_d       = ST_RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_write    = rst_n & ~freeze & ~do_load_stall;
  assign pc_src      = rst_n & do_branch;
  assign ifid_write  = rst_n & ~freeze & ~do_load_stall;
  assign ifid_flush  = ~rst_n | do_branch;
  assign idex_write  = rst_n & ~freeze;
  assign idex_flush  = ~rst_n | do_branch | do_load_stall;
  assign exmem_hold  = rst_n & freeze;
  assign exmem_flush = ~rst_n | do_branch | do_abort;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (rst_n && !pc_write && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (rst_n && do_branch && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed multi-cycle sequences, random vs model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  typedef struct packed {
    logic pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold, exmem_flush;
  } ctl_t;

  typedef struct {
    logic       rst_n;
    logic       lmr;
    logic [4:0] lrt, rs, rt;
    logic       br, zero, mrd, mwr, rdy;
  } in_t;

  typedef struct {
    in_t  in;
    ctl_t exp;
  } vec_t;

  localparam ctl_t CTL_DEF = 8'b1010_1000;
  localparam ctl_t CTL_LU  = 8'b0000_1100;
  localparam ctl_t CTL_BR  = 8'b1111_1101;
  localparam ctl_t CTL_FRZ = 8'b0000_0010;
  localparam ctl_t CTL_RST = 8'b0001_0101;
  localparam ctl_t CTL_TMO = 8'b1010_1001;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_mem_read, exmem_branch, exmem_zero, exmem_mem_read, exmem_mem_write, mem_ready;
  logic        pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_hold, exmem_flush, mem_timeout;
  logic [31:0] stall_cycles, flush_count;
  ctl_t        dut_ctl;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_hold(exmem_hold), .exmem_flush(exmem_flush),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign dut_ctl = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold, exmem_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic rn, input logic lmr, input logic [4:0] lrt,
                             input logic [4:0] rs, input logic [4:0] rt, input logic br,
                             input logic zero, input logic mrd, input logic mwr, input logic rdy);
    in_t v;
    v.rst_n = rn; v.lmr = lmr; v.lrt = lrt; v.rs = rs; v.rt = rt;
    v.br = br; v.zero = zero; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
    return v;
  endfunction

  task automatic set_in(input in_t v);
    rst_n = v.rst_n; idex_mem_read = v.lmr; idex_rt = v.lrt; id_rs = v.rs; id_rt = v.rt;
    exmem_branch = v.br; exmem_zero = v.zero; exmem_mem_read = v.mrd;
    exmem_mem_write = v.mwr; mem_ready = v.rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input string nm, input ctl_t exp);
    total++;
    if (dut_ctl !== exp) begin
      bad++;
      $display("FAIL %s: ctl got %b want %b (pcw,pcsrc,ifw,iff,idw,idf,hold,exf)", nm, dut_ctl, exp);
    end
  endtask

  task automatic expect_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_perf(input string nm, input longint st, input longint fl);
`ifdef HAZ_PERF_CNT_EN
    expect_val({nm, "_stall"}, stall_cycles, 32'(st));
    expect_val({nm, "_flush"}, flush_count, 32'(fl));
`else
    expect_val({nm, "_stall"}, stall_cycles, 32'd0);
    expect_val({nm, "_flush"}, flush_count, 32'd0 + 32'(fl - fl));
`endif
  endtask

  // Drive one cycle, compare control outputs mid-cycle, then advance past the edge.
  task automatic step(input string nm, input in_t v, input ctl_t exp);
    set_in(v);
    #2;
    expect_ctl(nm, exp);
    tick;
  endtask

  task automatic do_reset;
    set_in(mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
  endtask

  // Behavioural model: tracks "waiting on memory", how long, and whether the
  // next cycle is the one-cycle shadow after a stall/flush.
  bit     m_wait, m_shadow, m_tmo;
  int     m_waited;
  longint m_st, m_fl;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  task automatic model_eval(input in_t v, output ctl_t e);
    bit busy, br, lu;
    busy = (v.mrd || v.mwr) && !v.rdy;
    br   = v.br && v.zero;
    lu   = v.lmr && (v.lrt != 0) && ((v.lrt == v.rs) || (v.lrt == v.rt));
    e    = CTL_DEF;
    if (!v.rst_n) begin
      e = CTL_RST;
      m_wait = 0; m_shadow = 0; m_tmo = 0; m_waited = 0; m_st = 0; m_fl = 0;
      return;
    end
    if (m_wait) begin
      m_shadow = 0;
      if (!busy) m_wait = 0;
      else if (m_waited == TMO) begin
        e = CTL_TMO; m_tmo = 1; m_wait = 0;
      end else begin
        e = CTL_FRZ; m_waited++;
      end
    end else if (busy) begin
      e = CTL_FRZ; m_wait = 1; m_waited = 1; m_shadow = 0;
    end else if (m_shadow) begin
      m_shadow = 0;
    end else if (br) begin
      e = CTL_BR; m_shadow = 1;
      if (m_fl < SAT) m_fl++;
    end else if (lu) begin
      e = CTL_LU; m_shadow = 1;
    end
    if (!e.pc_write && m_st < SAT) m_st++;
  endtask

  vec_t tbl[14];
  in_t  idle, v;
  ctl_t e;
  bit   exp_tmo;
  longint exp_st, exp_fl;

  initial begin
    idle = mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //               rn lmr lrt rs rt br z mrd mwr rdy
    tbl[0].in  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  tbl[0].exp  = CTL_DEF;
    tbl[1].in  = mk(1, 1, 8, 8, 3, 0, 0, 0, 0, 0);  tbl[1].exp  = CTL_LU;
    tbl[2].in  = mk(1, 1, 9, 2, 9, 0, 0, 0, 0, 0);  tbl[2].exp  = CTL_LU;
    tbl[3].in  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  tbl[3].exp  = CTL_DEF;
    tbl[4].in  = mk(1, 0, 8, 8, 8, 0, 0, 0, 0, 0);  tbl[4].exp  = CTL_DEF;
    tbl[5].in  = mk(1, 1, 8, 7, 6, 0, 0, 0, 0, 0);  tbl[5].exp  = CTL_DEF;
    tbl[6].in  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);  tbl[6].exp  = CTL_BR;
    tbl[7].in  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);  tbl[7].exp  = CTL_DEF;
    tbl[8].in  = mk(1, 1, 8, 8, 0, 1, 1, 0, 0, 0);  tbl[8].exp  = CTL_BR;
    tbl[9].in  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  tbl[9].exp  = CTL_FRZ;
    tbl[10].in = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  tbl[10].exp = CTL_FRZ;
    tbl[11].in = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);  tbl[11].exp = CTL_DEF;
    tbl[12].in = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);  tbl[12].exp = CTL_DEF;
    tbl[13].in = mk(1, 1, 4, 4, 4, 1, 1, 0, 1, 0);  tbl[13].exp = CTL_FRZ;

    // Reset held for two cycles, then release into RUN.
    set_in(mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2; expect_ctl("rst_c0", CTL_RST); tick;
    #2; expect_ctl("rst_c1", CTL_RST); tick;
    set_in(idle); #2;
    expect_ctl("rst_release", CTL_DEF);
    expect_val("rst_tmo", {31'd0, mem_timeout}, 32'd0);
    check_perf("rst", 0, 0);
    tick;

    for (int i = 0; i < 14; i++) begin
      do_reset;
      step($sformatf("tbl%0d", i), tbl[i].in, tbl[i].exp);
    end

    // Load-use: exactly one bubble, then normal flow.
    do_reset;
    step("lu_stall", mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 0), CTL_LU);
    step("lu_after", mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 0), CTL_DEF);
    step("lu_idle", idle, CTL_DEF);
    step("lu_r0", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), CTL_DEF);

    // Taken branch wins over load-use; no stall follows.
    do_reset;
    step("br_flush", mk(1, 1, 8, 8, 0, 1, 1, 0, 0, 0), CTL_BR);
    set_in(idle); #2;
    expect_ctl("br_after", CTL_DEF);
    check_perf("br", 0, 1);
    tick;

    // Three-cycle memory wait released on the ready cycle.
    do_reset;
    for (int i = 0; i < 3; i++) step($sformatf("mw_frz%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), CTL_FRZ);
    step("mw_ready", mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1), CTL_DEF);
    set_in(idle); #2;
    expect_ctl("mw_after", CTL_DEF);
    check_perf("mw", 3, 0);
    tick;

    // Branch stuck behind a store: flush only on the first RUN cycle after ready.
    do_reset;
    for (int i = 0; i < 2; i++) step($sformatf("bm_frz%0d", i), mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0), CTL_FRZ);
    step("bm_ready", mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1), CTL_DEF);
    step("bm_flush", mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1), CTL_BR);
    set_in(idle); #2;
    check_perf("bm", 2, 1);
    tick;

    // Timeout: TMO freeze cycles, then abort with a sticky error flag.
    do_reset;
    for (int i = 0; i < TMO; i++) step($sformatf("to_frz%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), CTL_FRZ);
    set_in(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); #2;
    expect_ctl("to_abort", CTL_TMO);
    expect_val("to_tmo_pre", {31'd0, mem_timeout}, 32'd0);
    tick;
    for (int i = 0; i < 3; i++) begin
      set_in(idle); #2;
      expect_val($sformatf("to_sticky%0d", i), {31'd0, mem_timeout}, 32'd1);
      tick;
    end
    check_perf("to", TMO, 0);
    set_in(mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
    expect_val("to_in_rst", {31'd0, mem_timeout}, 32'd1);
    tick;
    set_in(idle); #2;
    expect_val("to_cleared", {31'd0, mem_timeout}, 32'd0);
    tick;

    // Reset in the middle of a memory stall overrides it at once.
    step("mr_frz0", mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), CTL_FRZ);
    step("mr_frz1", mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), CTL_FRZ);
    step("mr_rst", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), CTL_RST);
    step("mr_run", idle, CTL_DEF);

    // Randomized traffic against the model.
    do_reset;
    m_wait = 0; m_shadow = 0; m_tmo = 0; m_waited = 0; m_st = 0; m_fl = 0;
    for (int i = 0; i < 2000; i++) begin
      v = mk(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) < 2), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
             1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0));
      set_in(v);
      #2;
      exp_tmo = m_tmo; exp_st = m_st; exp_fl = m_fl;
      model_eval(v, e);
      expect_ctl($sformatf("rnd%0d", i), e);
      expect_val($sformatf("rnd%0d_tmo", i), {31'd0, mem_timeout}, {31'd0, exp_tmo});
      check_perf($sformatf("rnd%0d", i), exp_st, exp_fl);
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
